silly_kernel_mc: RTL and testbench

Parametrised multi-cycle successor to the single-cycle silly kernel. It keeps the same 32-bit instruction format: jump, branch, register write, write-source select, ALU op, three register addresses and an 8-bit constant. It adds the following:
- fetch from an external instruction memory over a req/ack handshake,
- a valid/ready handshake on the switch-input source,
- a HALT encoding,
- a debug read port that drives the board HEX displays.

It sits between the instruction memory, the board switches and the HEX decoders. It instantiates miriscv_alu.

---
 rtl/silly_kernel_mc_if.sv | 56 +++++
 rtl/silly_kernel_mc.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_silly_kernel_mc.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/silly_kernel_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : silly_kernel_mc_if
// Description : Bus bundle for silly_kernel_mc. Carries the instruction-fetch
//               req/ack channel, the switch-input valid/ready channel and the
//               debug register read port.
// Revision    : 1.0 - initial release
// ============================================================================
interface silly_kernel_mc_if #(
  parameter int XLEN = 32,
  parameter int IN_W = 10
) ();

  // Instruction memory channel
  logic [31:0]     imem_addr_o;
  logic            imem_req_o;
  logic            imem_ack_i;
  logic [31:0]     imem_rdata_i;

  // Switch input channel
  logic [IN_W-1:0] in_data_i;
  logic            in_valid_i;
  logic            in_ready_o;

  // Debug register read port (HEX displays)
  logic [4:0]      dbg_addr_i;
  logic [XLEN-1:0] dbg_data_o;

  // Kernel side
  modport master (
    output imem_addr_o,
    output imem_req_o,
    input  imem_ack_i,
    input  imem_rdata_i,
    input  in_data_i,
    input  in_valid_i,
    output in_ready_o,
    input  dbg_addr_i,
    output dbg_data_o
  );

  // Environment side (memory, switches, display decoders)
  modport slave (
    input  imem_addr_o,
    input  imem_req_o,
    output imem_ack_i,
    output imem_rdata_i,
    output in_data_i,
    output in_valid_i,
    input  in_ready_o,
    output dbg_addr_i,
    input  dbg_data_o
  );

endinterface
`default_nettype wire

// File: rtl/silly_kernel_mc.sv
`default_nettype none
// ============================================================================
// Module      : miriscv_alu
// Description : Combinational ALU used by silly_kernel_mc.
//               Op map: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL,
//               7 SRA, 8 EQ, 9 NE, 10 LT signed, 11 GE signed,
//               12 LT unsigned, 13 GE unsigned, 14/15 give zero.
//               Comparison ops return the outcome both as a 0/1 result and
//               on the flag; all other ops leave the flag low.
// Revision    : 1.0 - initial release
// ============================================================================
module miriscv_alu #(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_op_i,
  input  logic [XLEN-1:0] alu_a_i,
  input  logic [XLEN-1:0] alu_b_i,
  output logic [XLEN-1:0] alu_result_o,
  output logic            alu_flag_o
);

  localparam int SHW = (XLEN > 1) ? $clog2(XLEN) : 1;

  localparam logic [3:0] c_OP_ADD  = 4'd0;
  localparam logic [3:0] c_OP_SUB  = 4'd1;
  localparam logic [3:0] c_OP_XOR  = 4'd2;
  localparam logic [3:0] c_OP_OR   = 4'd3;
  localparam logic [3:0] c_OP_AND  = 4'd4;
  localparam logic [3:0] c_OP_SLL  = 4'd5;
  localparam logic [3:0] c_OP_SRL  = 4'd6;
  localparam logic [3:0] c_OP_SRA  = 4'd7;
  localparam logic [3:0] c_OP_EQ   = 4'd8;
  localparam logic [3:0] c_OP_NE   = 4'd9;
  localparam logic [3:0] c_OP_LTS  = 4'd10;
  localparam logic [3:0] c_OP_GES  = 4'd11;
  localparam logic [3:0] c_OP_LTU  = 4'd12;
  localparam logic [3:0] c_OP_GEU  = 4'd13;

  logic [SHW-1:0] w_shamt;
  logic           w_cmp;
  logic           w_is_cmp;

  assign w_shamt = alu_b_i[SHW-1:0];

  // Comparison outcome for the compare ops, shared by result and flag
  always_comb begin
    w_cmp    = 1'b0;
    w_is_cmp = 1'b1;
    case (alu_op_i)
      c_OP_EQ:  w_cmp = (alu_a_i == alu_b_i);
      c_OP_NE:  w_cmp = (alu_a_i != alu_b_i);
      c_OP_LTS: w_cmp = ($signed(alu_a_i) <  $signed(alu_b_i));
      c_OP_GES: w_cmp = ($signed(alu_a_i) >= $signed(alu_b_i));
      c_OP_LTU: w_cmp = (alu_a_i <  alu_b_i);
      c_OP_GEU: w_cmp = (alu_a_i >= alu_b_i);
      default:  w_is_cmp = 1'b0;
    endcase
  end

  // Arithmetic / logic result select
  always_comb begin
    alu_result_o = '0;
    alu_flag_o   = 1'b0;
    case (alu_op_i)
      c_OP_ADD: alu_result_o = alu_a_i + alu_b_i;
      c_OP_SUB: alu_result_o = alu_a_i - alu_b_i;
      c_OP_XOR: alu_result_o = alu_a_i ^ alu_b_i;
      c_OP_OR:  alu_result_o = alu_a_i | alu_b_i;
      c_OP_AND: alu_result_o = alu_a_i & alu_b_i;
      c_OP_SLL: alu_result_o = alu_a_i << w_shamt;
      c_OP_SRL: alu_result_o = alu_a_i >> w_shamt;
      c_OP_SRA: alu_result_o = XLEN'($signed(alu_a_i) >>> w_shamt);
      default: begin
        if (w_is_cmp) begin
          alu_result_o = XLEN'(w_cmp);
          alu_flag_o   = w_cmp;
        end
      end
    endcase
  end

endmodule

// ============================================================================
// Module      : silly_kernel_mc
// Description : Multi-cycle silly kernel. Fetches 32-bit instructions over a
//               req/ack handshake, executes them through miriscv_alu, waits
//               on a valid/ready switch input for input-sourced writes,
//               supports a HALT encoding and exposes a combinational debug
//               register read for the HEX displays.
// Revision    : 1.0 - initial release
// ============================================================================
module silly_kernel_mc #(
  parameter int          XLEN       = 32,
  parameter int          RF_DEPTH   = 32,
  parameter int          IN_W       = 10,
  parameter logic [31:0] RESET_ADDR = 32'h66000000
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  silly_kernel_mc_if.master  bus,
  output logic [31:0]        pc_o,
  output logic               halted_o,
  output logic               retire_o
);

  localparam int AW = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;

  // Write-source encodings
  localparam logic [1:0] c_WS_CONST = 2'b00;
  localparam logic [1:0] c_WS_INPUT = 2'b01;
  localparam logic [1:0] c_WS_ALU   = 2'b10;
  localparam logic [1:0] c_WS_HALT  = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_EXEC    = 3'd1,
    S_WAIT_IN = 3'd2,
    S_WB      = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_req;
  logic [31:0]       r_pc;
  logic [31:0]       r_ir;
  logic [XLEN-1:0]   r_alu;
  logic              r_flag;
  logic [XLEN-1:0]   r_in;
  logic [XLEN-1:0]   r_rf [RF_DEPTH];

  // Instruction fields
  logic              w_jump;
  logic              w_branch;
  logic              w_we;
  logic [1:0]        w_ws;
  logic [3:0]        w_op;
  logic [AW-1:0]     w_a1;
  logic [AW-1:0]     w_a2;
  logic [AW-1:0]     w_wa;
  logic [7:0]        w_const;

  logic [XLEN-1:0]   w_se;
  logic [31:0]       w_off;
  logic [XLEN-1:0]   w_rs1;
  logic [XLEN-1:0]   w_rs2;
  logic [XLEN-1:0]   w_alu_res;
  logic              w_alu_flag;
  logic [XLEN-1:0]   w_wb_data;
  logic              w_take;
  logic [31:0]       w_pc_nxt;
  logic              w_fetch_hit;
  logic              w_in_hit;
  logic              w_rf_wr;
  logic [AW-1:0]     w_dbg_idx;

  assign w_jump   = r_ir[31];
  assign w_branch = r_ir[30];
  assign w_we     = r_ir[29];
  assign w_ws     = r_ir[28:27];
  assign w_op     = r_ir[26:23];
  assign w_a1     = r_ir[18 +: AW];
  assign w_a2     = r_ir[13 +: AW];
  assign w_wa     = r_ir[8 +: AW];
  assign w_const  = r_ir[7:0];

  // Constant sign-extended to the datapath, and as a word offset for the PC
  assign w_se     = XLEN'($signed(w_const));
  assign w_off    = {{22{w_const[7]}}, w_const, 2'b00};

  // A fetch only completes while a request is actually outstanding
  assign w_fetch_hit = (r_state == S_FETCH) && r_req && bus.imem_ack_i;
  assign w_in_hit    = (r_state == S_WAIT_IN) && bus.in_valid_i;

  // Register 0 is never written, so reading it returns its reset value 0
  assign w_rs1     = (int'(w_a1) < RF_DEPTH) ? r_rf[w_a1] : '0;
  assign w_rs2     = (int'(w_a2) < RF_DEPTH) ? r_rf[w_a2] : '0;
  assign w_dbg_idx = bus.dbg_addr_i[AW-1:0];

  miriscv_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .alu_op_i     (w_op),
    .alu_a_i      (w_rs1),
    .alu_b_i      (w_rs2),
    .alu_result_o (w_alu_res),
    .alu_flag_o   (w_alu_flag)
  );

  // Next-state decision for the instruction sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_fetch_hit) begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_ws == c_WS_HALT) begin
          w_state_nxt = S_HALT;
        end else if (w_we && (w_ws == c_WS_INPUT)) begin
          w_state_nxt = S_WAIT_IN;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_WAIT_IN: begin
        if (bus.in_valid_i) begin
          w_state_nxt = S_WB;
        end
      end
      S_WB:    w_state_nxt = S_FETCH;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // State register; the fetch request is registered so that it is low while
  // reset is held and rises on the first edge spent in FETCH
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_FETCH;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == S_FETCH);
    end
  end

  // Instruction register loads on the acknowledged fetch cycle only
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ir <= '0;
    end else if (w_fetch_hit) begin
      r_ir <= bus.imem_rdata_i;
    end
  end

  // Execute stage result and comparison flag
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_alu  <= '0;
      r_flag <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_alu  <= w_alu_res;
      r_flag <= w_alu_flag;
    end
  end

  // Switch input capture, zero-extended to the datapath
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_in <= '0;
    end else if (w_in_hit) begin
      r_in <= XLEN'(bus.in_data_i);
    end
  end

  // Write-back source select
  always_comb begin
    w_wb_data = w_se;
    case (w_ws)
      c_WS_CONST: w_wb_data = w_se;
      c_WS_INPUT: w_wb_data = r_in;
      c_WS_ALU:   w_wb_data = r_alu;
      default:    w_wb_data = '0;
    endcase
  end

  assign w_rf_wr  = (r_state == S_WB) && w_we && (w_wa != '0) && (int'(w_wa) < RF_DEPTH);
  assign w_take   = w_jump || (w_branch && r_flag);
  assign w_pc_nxt = w_take ? (r_pc + w_off) : (r_pc + 32'd4);

  // Register file write port; register 0 is excluded from writes
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_rf_wr) begin
      r_rf[w_wa] <= w_wb_data;
    end
  end

  // Program counter advances once per retired instruction
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_pc <= RESET_ADDR;
    end else if (r_state == S_WB) begin
      r_pc <= w_pc_nxt;
    end
  end

  assign bus.imem_addr_o = r_pc;
  assign bus.imem_req_o  = r_req;
  assign bus.in_ready_o  = (r_state == S_WAIT_IN);
  assign bus.dbg_data_o  = (int'(w_dbg_idx) < RF_DEPTH) ? r_rf[w_dbg_idx] : '0;

  assign pc_o     = r_pc;
  assign halted_o = (r_state == S_HALT);
  assign retire_o = (r_state == S_WB);

endmodule
`default_nettype wire

// File: tb/tb_silly_kernel_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_silly_kernel_mc
// Description : Self-checking bench for silly_kernel_mc: directed vector
//               table, randomized instructions against a reference model,
//               halt, asynchronous reset and address wrap sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_silly_kernel_mc;

  localparam int          XLEN   = 32;
  localparam int          IN_W   = 10;
  localparam logic [31:0] c_RST  = 32'h66000000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  silly_kernel_mc_if #(.XLEN(XLEN), .IN_W(IN_W)) bus ();
  silly_kernel_mc_if #(.XLEN(XLEN), .IN_W(IN_W)) bus2 ();

  logic [31:0] pc, pc2;
  logic        halted, halted2, retire, retire2;

  silly_kernel_mc #(
    .XLEN(XLEN), .RF_DEPTH(32), .IN_W(IN_W), .RESET_ADDR(c_RST)
  ) u_dut (
    .clk_i(clk), .reset_n_i(reset_n), .bus(bus),
    .pc_o(pc), .halted_o(halted), .retire_o(retire)
  );

  // Second instance starts near the top of the address space for the wrap case
  silly_kernel_mc #(
    .XLEN(XLEN), .RF_DEPTH(32), .IN_W(IN_W), .RESET_ADDR(32'hFFFFFF00)
  ) u_dut_wrap (
    .clk_i(clk), .reset_n_i(reset_n), .bus(bus2),
    .pc_o(pc2), .halted_o(halted2), .retire_o(retire2)
  );

  typedef struct {
    logic [31:0]     instr;
    int              ack_dly;
    int              in_dly;
    logic [IN_W-1:0] in_val;
    logic [4:0]      rd;
    logic [31:0]     exp_rd;
    logic [31:0]     exp_pc;
  } vec_t;

  vec_t        tbl [9];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] m_rf [32];
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic dbg_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    bus.dbg_addr_i = a;
    #1;
    chk(name, bus.dbg_data_o, exp);
  endtask

  function automatic void alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic f);
    r = 32'd0;
    f = 1'b0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a ^ b;
      4'd3:  r = a | b;
      4'd4:  r = a & b;
      4'd5:  r = a << b[4:0];
      4'd6:  r = a >> b[4:0];
      4'd7:  r = 32'($signed(a) >>> b[4:0]);
      4'd8:  f = (a == b);
      4'd9:  f = (a != b);
      4'd10: f = ($signed(a) <  $signed(b));
      4'd11: f = ($signed(a) >= $signed(b));
      4'd12: f = (a <  b);
      4'd13: f = (a >= b);
      default: f = 1'b0;
    endcase
    if (op >= 4'd8 && op <= 4'd13) r = {31'd0, f};
  endfunction

  // Architectural effect of one non-halt instruction
  task automatic model_step(input logic [31:0] ins, input logic [IN_W-1:0] inv);
    logic [31:0] a, b, r, se;
    logic        f;
    a  = m_rf[ins[22:18]];
    b  = m_rf[ins[17:13]];
    alu_ref(ins[26:23], a, b, r, f);
    se = {{24{ins[7]}}, ins[7:0]};
    if (ins[29] && ins[12:8] != 5'd0) begin
      if (ins[28:27] == 2'b00)      m_rf[ins[12:8]] = se;
      else if (ins[28:27] == 2'b01) m_rf[ins[12:8]] = 32'(inv);
      else                          m_rf[ins[12:8]] = r;
    end
    if (ins[31] || (ins[30] && f)) m_pc = m_pc + (se << 2);
    else                           m_pc = m_pc + 32'd4;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_pc = c_RST;
  endtask

  // Serve one instruction; entered and left at a falling edge in FETCH
  task automatic exec_instr(input logic [31:0] ins, input int ack_dly, input int in_dly,
                            input logic [IN_W-1:0] inv);
    int  k;
    bit  is_in;
    is_in = ins[29] && (ins[28:27] == 2'b01);
    k = 0;
    while (bus.imem_req_o !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk("fetch_req", 32'(bus.imem_req_o), 32'd1);
    chk("fetch_addr", bus.imem_addr_o, m_pc);
    if (!is_in) begin
      bus.in_valid_i = 1'($urandom);
      bus.in_data_i  = IN_W'($urandom);
    end
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      chk("addr_hold", bus.imem_addr_o, m_pc);
    end
    bus.imem_ack_i   = 1'b1;
    bus.imem_rdata_i = ins;
    @(negedge clk);
    bus.imem_ack_i   = 1'b0;
    bus.imem_rdata_i = $urandom;
    chk("exec_quiet", 32'({bus.imem_req_o, bus.in_ready_o, retire}), 32'd0);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    if (ins[28:27] == 2'b11) return;
    if (is_in) begin
      for (int i = 0; i < in_dly; i++) begin
        chk("wait_ready", 32'({bus.in_ready_o, retire}), 32'd2);
        bus.in_data_i = IN_W'($urandom);
        @(negedge clk);
      end
      chk("wait_ready", 32'({bus.in_ready_o, retire}), 32'd2);
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = inv;
      @(negedge clk);
      bus.in_valid_i = 1'b0;
      bus.in_data_i  = IN_W'($urandom);
    end
    chk("retire", 32'({retire, bus.in_ready_o}), 32'd2);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0]     ins;
    logic [IN_W-1:0] inv;
    int              k;

    tbl[0] = '{32'h20000105, 0, 0, 10'h000, 5'd1, 32'h00000005, 32'h66000004};
    tbl[1] = '{32'h28000200, 0, 4, 10'h3FF, 5'd2, 32'h000003FF, 32'h66000008};
    tbl[2] = '{32'h20000207, 1, 0, 10'h000, 5'd2, 32'h00000007, 32'h6600000C};
    tbl[3] = '{32'h30044300, 0, 0, 10'h000, 5'd3, 32'h0000000C, 32'h66000010};
    tbl[4] = '{32'h800000FF, 0, 0, 10'h000, 5'd0, 32'h00000000, 32'h6600000C};
    tbl[5] = '{32'h44000002, 2, 0, 10'h000, 5'd3, 32'h0000000C, 32'h66000014};
    tbl[6] = '{32'h44800002, 0, 0, 10'h000, 5'd1, 32'h00000005, 32'h66000018};
    tbl[7] = '{32'h20000011, 3, 0, 10'h000, 5'd0, 32'h00000000, 32'h6600001C};
    tbl[8] = '{32'hA00004FC, 0, 0, 10'h000, 5'd4, 32'hFFFFFFFC, 32'h6600000C};

    bus.imem_ack_i    = 1'b0;  bus.imem_rdata_i  = 32'd0;
    bus.in_data_i     = '0;    bus.in_valid_i    = 1'b0;
    bus.dbg_addr_i    = 5'd0;
    bus2.imem_ack_i   = 1'b1;  bus2.imem_rdata_i = 32'h8000007F;
    bus2.in_data_i    = '0;    bus2.in_valid_i   = 1'b0;
    bus2.dbg_addr_i   = 5'd0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outputs", 32'({bus.imem_req_o, bus.in_ready_o, halted, retire}), 32'd0);
    chk("rst_pc", pc, c_RST);
    chk("rst_addr", bus.imem_addr_o, c_RST);
    chk("rst_pc_wrap", pc2, 32'hFFFFFF00);
    dbg_chk("rst_r5", 5'd5, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("req_low_at_release", 32'(bus.imem_req_o), 32'd0);
    @(negedge clk);
    chk("req_first_edge", 32'(bus.imem_req_o), 32'd1);

    // Jump past the top of the address space wraps silently
    k = 0;
    while (retire2 !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("wrap_retire", 32'(retire2), 32'd1);
    @(negedge clk);
    chk("wrap_pc", pc2, 32'h000000FC);

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      exec_instr(tbl[i].instr, tbl[i].ack_dly, tbl[i].in_dly, tbl[i].in_val);
      model_step(tbl[i].instr, tbl[i].in_val);
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].exp_pc);
      dbg_chk($sformatf("tbl%0d_reg", i), tbl[i].rd, tbl[i].exp_rd);
    end
    dbg_chk("tbl_r0", 5'd0, 32'd0);

    // Randomized instructions against the reference model
    for (int n = 0; n < 40; n++) begin
      ins = $urandom;
      if (ins[28:27] == 2'b11) ins[28:27] = 2'b10;
      inv = IN_W'($urandom);
      exec_instr(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), inv);
      model_step(ins, inv);
      chk("rnd_pc", pc, m_pc);
      dbg_chk("rnd_wa", ins[12:8], m_rf[ins[12:8]]);
      k = int'($urandom_range(0, 31));
      dbg_chk("rnd_any", 5'(k), m_rf[k]);
    end

    // Halt: frozen, no request, no retire, stray acks ignored
    exec_instr(32'h18000000, 0, 0, '0);
    bus.imem_ack_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("halt_flags", 32'({halted, bus.imem_req_o, retire}), 32'd4);
      chk("halt_pc", pc, m_pc);
      @(negedge clk);
    end
    bus.imem_ack_i = 1'b0;

    // Reset leaves HALT immediately
    reset_n = 1'b0;
    #1;
    chk("halt_reset", 32'({halted, bus.imem_req_o}), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    exec_instr(32'h20000105, 0, 0, '0);
    model_step(32'h20000105, '0);
    dbg_chk("post_halt_r1", 5'd1, 32'd5);

    // Asynchronous reset while waiting for input abandons the write
    k = 0;
    while (bus.imem_req_o !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk("wi_addr", bus.imem_addr_o, 32'h66000004);
    bus.imem_ack_i   = 1'b1;
    bus.imem_rdata_i = 32'h28000200;
    @(negedge clk);
    bus.imem_ack_i   = 1'b0;
    @(negedge clk);
    chk("wi_ready", 32'(bus.in_ready_o), 32'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("wi_ready_drop", 32'({bus.in_ready_o, bus.imem_req_o, retire}), 32'd0);
    chk("wi_pc", pc, c_RST);
    @(negedge clk);
    for (int r = 0; r < 32; r++) begin
      dbg_chk($sformatf("wi_reg%0d", r), 5'(r), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("restart_req", 32'(bus.imem_req_o), 32'd1);
    chk("restart_addr", bus.imem_addr_o, c_RST);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
